// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: synchronizes the frame sync and keys, then steps the game
// through serve, play, miss and game-over phases, tracking lives and BCD score.
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs,
  input  logic        start_n,
  input  logic        pause_n,
  input  logic        hit,
  input  logic        lose,
  output logic        frame_tick,
  output logic        ball_run,
  output logic        ball_hold,
  output logic [1:0]  lives,
  output logic [15:0] score_bcd,
  output logic [2:0]  state,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);

  state_t      state_q, state_d;
  logic [1:0]  lives_d;
  logic [15:0] score_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        paused_q, paused_d;

  // [0],[1] synchronizer stages, [2] edge-detect history; all idle high
  logic [2:0] vs_sync, start_sync, pause_sync;
  logic       start_p, pause_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_sync    <= '1;
      start_sync <= '1;
      pause_sync <= '1;
      frame_tick <= 1'b0;
      start_p    <= 1'b0;
      pause_p    <= 1'b0;
    end else begin
      vs_sync    <= {vs_sync[1:0], vs};
      start_sync <= {start_sync[1:0], start_n};
      pause_sync <= {pause_sync[1:0], pause_n};
      frame_tick <= vs_sync[2] & ~vs_sync[1];
      start_p    <= start_sync[2] & ~start_sync[1];
      pause_p    <= pause_sync[2] & ~pause_sync[1];
    end
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    lives_d  = lives;
    score_d  = score_bcd;
    cnt_d    = cnt_q;
    paused_d = paused_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_p) begin
          state_d  = S_SERVE;
          lives_d  = LIVES_INIT;
          score_d  = 16'h0000;
          cnt_d    = 8'd0;
          paused_d = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (pause_p) paused_d = ~paused_q;
        if (!paused_q) begin
          if (hit) score_d = bcd_inc(score_bcd);
          if (frame_tick && lose) begin
            state_d = S_MISS;
            lives_d = lives - 2'd1;
            cnt_d   = 8'd0;
          end
        end
      end
      S_MISS: begin
        if (frame_tick) begin
          if (cnt_q == MISS_LAST) begin
            state_d  = (lives == 2'd0) ? S_OVER : S_SERVE;
            cnt_d    = 8'd0;
            paused_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lives     <= LIVES_INIT;
      score_bcd <= 16'h0000;
      cnt_q     <= 8'd0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives     <= lives_d;
      score_bcd <= score_d;
      cnt_q     <= cnt_d;
      paused_q  <= paused_d;
    end
  end

  assign state     = state_q;
  assign ball_run  = (state_q == S_PLAY) && !paused_q;
  assign ball_hold = (state_q == S_IDLE) || (state_q == S_SERVE) ||
                     (state_q == S_MISS) || (state_q == S_OVER);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a small expected-value queue.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        start_n = 1'b1;
  logic        pause_n = 1'b1;
  logic        hit = 1'b0;
  logic        lose = 1'b0;
  logic        frame_tick, ball_run, ball_hold, game_over;
  logic [1:0]  lives;
  logic [15:0] score_bcd;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int tick_mark;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  pong_game_ctrl #(.LIVES(2), .SERVE_FRAMES(2), .MISS_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .start_n(start_n), .pause_n(pause_n),
    .hit(hit), .lose(lose), .frame_tick(frame_tick), .ball_run(ball_run),
    .ball_hold(ball_hold), .lives(lives), .score_bcd(score_bcd), .state(state),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_tick === 1'b1) tick_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_v(input logic [15:0] obs);
    logic [15:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic frame();
    vs = 1'b0;
    step(4);
    vs = 1'b1;
    step(4);
  endtask

  task automatic press_start();
    start_n = 1'b0;
    step(5);
    start_n = 1'b1;
    step(4);
  endtask

  task automatic press_pause();
    pause_n = 1'b0;
    step(5);
    pause_n = 1'b1;
    step(4);
  endtask

  initial begin
    // reset values
    expect_v("rst_state", 16'd0); expect_v("rst_lives", 16'd2);
    expect_v("rst_score", 16'h0000); expect_v("rst_tick", 16'd0);
    expect_v("rst_run", 16'd0); expect_v("rst_hold", 16'd1);
    expect_v("rst_over", 16'd0);
    step(2);
    check_v(16'(state)); check_v(16'(lives)); check_v(score_bcd);
    check_v(16'(frame_tick)); check_v(16'(ball_run)); check_v(16'(ball_hold));
    check_v(16'(game_over));
    tick_mark = tick_cnt;
    expect_v("no_tick_after_release", 16'(tick_mark));
    rst_n = 1'b1;
    step(8);
    check_v(16'(tick_cnt));

    // start -> SERVE
    expect_v("start_state", 16'd1); expect_v("start_lives", 16'd2);
    expect_v("start_score", 16'h0000);
    press_start();
    check_v(16'(state)); check_v(16'(lives)); check_v(score_bcd);

    // first frame: tick on the 3rd edge after vs falls, still serving
    expect_v("tick_latency", 16'd1); expect_v("serve_after_1", 16'd1);
    vs = 1'b0;
    step(3);
    check_v(16'(frame_tick));
    step(1);
    vs = 1'b1;
    step(4);
    check_v(16'(state));

    expect_v("play_state", 16'd2); expect_v("play_run", 16'd1);
    expect_v("play_hold", 16'd0);
    frame();
    check_v(16'(state)); check_v(16'(ball_run)); check_v(16'(ball_hold));

    // lose without a frame tick is ignored
    expect_v("lose_no_tick", 16'd2);
    lose = 1'b1; step(3); lose = 1'b0; step(1);
    check_v(16'(state));

    // 12 hits
    expect_v("score_12", 16'h0012);
    for (int i = 0; i < 12; i++) begin
      hit = 1'b1; step(1); hit = 1'b0; step(1);
    end
    check_v(score_bcd);

    // pause: run drops, hit and lose+tick ignored, resume on second press
    expect_v("paused_run", 16'd0); expect_v("paused_score", 16'h0012);
    expect_v("paused_state", 16'd2); expect_v("paused_lives", 16'd2);
    expect_v("resume_run", 16'd1);
    press_pause();
    check_v(16'(ball_run));
    hit = 1'b1; step(1); hit = 1'b0; step(1);
    check_v(score_bcd);
    lose = 1'b1; frame(); lose = 1'b0;
    check_v(16'(state)); check_v(16'(lives));
    press_pause();
    check_v(16'(ball_run));

    // hit coincident with lose+tick
    expect_v("coinc_score", 16'h0013); expect_v("coinc_state", 16'd3);
    expect_v("coinc_lives", 16'd1);
    lose = 1'b1; vs = 1'b0;
    step(3);
    hit = 1'b1;
    step(1);
    hit = 1'b0; lose = 1'b0; vs = 1'b1;
    step(4);
    check_v(score_bcd); check_v(16'(state)); check_v(16'(lives));

    // pause key outside PLAY is ignored, miss lasts 3 ticks
    expect_v("miss_after_2", 16'd3); expect_v("serve_after_miss", 16'd1);
    press_pause();
    frame(); frame();
    check_v(16'(state));
    frame();
    check_v(16'(state));

    expect_v("play_again", 16'd2); expect_v("play_again_run", 16'd1);
    frame(); frame();
    check_v(16'(state)); check_v(16'(ball_run));

    expect_v("miss2_state", 16'd3); expect_v("miss2_lives", 16'd0);
    lose = 1'b1; frame(); lose = 1'b0;
    check_v(16'(state)); check_v(16'(lives));

    expect_v("over_state", 16'd4); expect_v("over_flag", 16'd1);
    expect_v("over_hold", 16'd1);
    frame(); frame(); frame();
    check_v(16'(state)); check_v(16'(game_over)); check_v(16'(ball_hold));

    // restart from OVER
    expect_v("restart_state", 16'd1); expect_v("restart_lives", 16'd2);
    expect_v("restart_score", 16'h0000); expect_v("restart_over", 16'd0);
    press_start();
    check_v(16'(state)); check_v(16'(lives)); check_v(score_bcd);
    check_v(16'(game_over));

    // start in SERVE ignored; serve counter restarted on entry
    expect_v("start_in_serve", 16'd1); expect_v("serve_1_tick", 16'd1);
    expect_v("serve_2_ticks", 16'd2);
    press_start();
    check_v(16'(state));
    frame();
    check_v(16'(state));
    frame();
    check_v(16'(state));

    // 9999 saturation
    expect_v("score_9999", 16'h9999); expect_v("score_sat", 16'h9999);
    hit = 1'b1;
    step(9999);
    hit = 1'b0;
    step(1);
    check_v(score_bcd);
    hit = 1'b1; step(1); hit = 1'b0; step(1);
    check_v(score_bcd);

    // reset mid-MISS with a frame sync in flight
    expect_v("pre_rst_state", 16'd3);
    lose = 1'b1; frame(); lose = 1'b0;
    check_v(16'(state));
    expect_v("midrst_state", 16'd0); expect_v("midrst_lives", 16'd2);
    expect_v("midrst_score", 16'h0000); expect_v("midrst_hold", 16'd1);
    vs = 1'b0;
    step(2);
    rst_n = 1'b0;
    step(1);
    check_v(16'(state)); check_v(16'(lives)); check_v(score_bcd);
    check_v(16'(ball_hold));
    tick_mark = tick_cnt;
    expect_v("midrst_no_tick", 16'(tick_mark)); expect_v("midrst_idle", 16'd0);
    vs = 1'b1;
    rst_n = 1'b1;
    step(8);
    check_v(16'(tick_cnt)); check_v(16'(state));

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
